// File: rtl/datamover_validator.sv
// datamover_validator: writes an incrementing pattern through a DataMover S2MM channel, reads it back over MM2S and counts every error.
// Optional build macro DMV_LOOP_EN: clean passes repeat with an advancing address and seed, and o_loop_cnt is added.
module datamover_validator #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int unsigned LENGTH_BYTES   = 1024,
    parameter logic [63:0] SEED           = 64'h0123_4567_89AB_0000,
    parameter logic [3:0]  CMD_TAG        = 4'h5,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_s2mm_wr_cmd_tready,
    output logic [71:0] o_s2mm_wr_cmd_tdata,
    output logic        o_s2mm_wr_cmd_tvalid,
    output logic [63:0] o_s2mm_wr_tdata,
    output logic [7:0]  o_s2mm_wr_tkeep,
    output logic        o_s2mm_wr_tvalid,
    output logic        o_s2mm_wr_tlast,
    input  logic        i_s2mm_wr_tready,
    input  logic [7:0]  i_s2mm_sts_tdata,
    input  logic        i_s2mm_sts_tvalid,
    input  logic        i_s2mm_sts_tkeep,
    input  logic        i_s2mm_sts_tlast,
    input  logic        i_mm2s_rd_cmd_tready,
    output logic [71:0] o_mm2s_rd_cmd_tdata,
    output logic        o_mm2s_rd_cmd_tvalid,
    input  logic [63:0] i_mm2s_rd_tdata,
    input  logic [7:0]  i_mm2s_rd_tkeep,
    input  logic        i_mm2s_rd_tvalid,
    input  logic        i_mm2s_rd_tlast,
    output logic        o_mm2s_rd_tready,
    output logic        o_done,
    output logic        o_pass,
`ifdef DMV_LOOP_EN
    output logic [15:0] o_loop_cnt,
`endif
    output logic [15:0] o_err_cnt
);
    localparam logic [2:0]  IDLE = 3'd0, WR_CMD = 3'd1, WR_DATA = 3'd2, WR_STS = 3'd3;
    localparam logic [2:0]  RD_CMD = 3'd4, RD_DATA = 3'd5, DONE = 3'd6;
    localparam logic [19:0] LAST = 20'(LENGTH_BYTES / 8 - 1);
    localparam logic [22:0] BTT = 23'(LENGTH_BYTES);

    logic [2:0]  state, state_nxt;
    logic [19:0] cnt;
    logic [15:0] err;
    logic [31:0] wd, addr;
    logic [63:0] seed, exp_data;
    logic [71:0] cmd;
    logic [1:0]  inc;
    logic [16:0] err_sum;
    logic        hs, last, timeout, sts_bad, mism, again, unused;

    assign unused   = ^{i_s2mm_sts_tkeep, i_s2mm_sts_tlast};
    assign cmd      = {4'h0, CMD_TAG, addr, 8'h40, 1'b1, BTT};
    assign exp_data = seed + 64'(cnt);
    assign last     = cnt == LAST;
    assign sts_bad  = !(i_s2mm_sts_tdata[7] && i_s2mm_sts_tdata[6:4] == 3'd0 && i_s2mm_sts_tdata[3:0] == CMD_TAG);
    assign hs       = (state == WR_CMD && i_s2mm_wr_cmd_tready) || (state == WR_DATA && i_s2mm_wr_tready) ||
                      (state == WR_STS && i_s2mm_sts_tvalid) || (state == RD_CMD && i_mm2s_rd_cmd_tready) ||
                      (state == RD_DATA && i_mm2s_rd_tvalid);
    assign timeout  = TIMEOUT_CYCLES != 0 && state != IDLE && state != DONE && !hs &&
                      wd >= 32'(TIMEOUT_CYCLES - 1);
    assign err_sum  = {1'b0, err} + 17'(inc);

    assign o_s2mm_wr_cmd_tvalid = state == WR_CMD;
    assign o_s2mm_wr_cmd_tdata  = o_s2mm_wr_cmd_tvalid ? cmd : '0;
    assign o_s2mm_wr_tvalid     = state == WR_DATA;
    assign o_s2mm_wr_tdata      = o_s2mm_wr_tvalid ? exp_data : '0;
    assign o_s2mm_wr_tkeep      = o_s2mm_wr_tvalid ? 8'hFF : 8'h00;
    assign o_s2mm_wr_tlast      = o_s2mm_wr_tvalid && last;
    assign o_mm2s_rd_cmd_tvalid = state == RD_CMD;
    assign o_mm2s_rd_cmd_tdata  = o_mm2s_rd_cmd_tvalid ? cmd : '0;
    assign o_mm2s_rd_tready     = state == RD_DATA;
    assign o_pass               = o_done && err == '0;
    assign o_err_cnt            = err;

    // Per-cycle error increment: watchdog, bad status, or read-beat faults (data, keep, tlast placement)
    always_comb begin
        mism = 1'b0;
        for (int b = 0; b < 8; b++)
            mism = mism | (i_mm2s_rd_tkeep[b] && i_mm2s_rd_tdata[8*b +: 8] != exp_data[8*b +: 8]);
        inc = 2'd0;
        if (timeout) inc = 2'd1;
        else if (state == WR_STS && i_s2mm_sts_tvalid) inc = {1'b0, sts_bad};
        else if (state == RD_DATA && i_mm2s_rd_tvalid)
            inc = 2'(mism) + 2'(i_mm2s_rd_tkeep != 8'hFF) + 2'(i_mm2s_rd_tlast != last);
    end

    // Next-state selection; the watchdog overrides every active state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = WR_CMD;
            WR_CMD:  state_nxt = hs ? WR_DATA : WR_CMD;
            WR_DATA: state_nxt = hs && last ? WR_STS : WR_DATA;
            WR_STS:  state_nxt = hs ? (sts_bad ? DONE : RD_CMD) : WR_STS;
            RD_CMD:  state_nxt = hs ? RD_DATA : RD_CMD;
            RD_DATA: state_nxt = hs && (i_mm2s_rd_tlast || last) ? DONE : RD_DATA;
            DONE:    state_nxt = again ? WR_CMD : DONE;
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = DONE;
    end

    // Main sequencer: state, beat counter, watchdog and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            wd    <= '0;
            err   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= state_nxt != state ? 20'd0 : (hs && (state == WR_DATA || state == RD_DATA)) ? cnt + 20'd1 : cnt;
            wd    <= (hs || state_nxt != state) ? 32'd0 : wd + 32'd1;
            err   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

`ifdef DMV_LOOP_EN
    logic [3:0]  idle;
    logic [32:0] nxt_addr;

    assign nxt_addr = {1'b0, addr} + 33'(LENGTH_BYTES);
    assign again    = state == DONE && err == '0 && idle == 4'd15;
    assign o_done   = state == DONE && (err != '0 || idle == 4'd0);

    // Clean passes restart after 16 idle cycles on the next region with the next seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= BASE_ADDR;
            seed       <= SEED;
            idle       <= '0;
            o_loop_cnt <= '0;
        end else begin
            idle <= state == DONE ? idle + 4'd1 : 4'd0;
            if (state == DONE && err == '0 && idle == 4'd0) o_loop_cnt <= o_loop_cnt + 16'd1;
            if (again) begin
                addr <= nxt_addr + 33'(LENGTH_BYTES) > {1'b0, BASE_ADDR} + 33'h1_0000 ? BASE_ADDR : nxt_addr[31:0];
                seed <= seed + 64'd1;
            end
        end
    end
`else
    assign again  = 1'b0;
    assign o_done = state == DONE;
    assign addr   = BASE_ADDR;
    assign seed   = SEED;
`endif
endmodule

// File: tb/tb_datamover_validator.sv
// tb_datamover_validator: drives the validator against a behavioural DataMover + memory with random stalls and injected faults.
module tb_datamover_validator;
    localparam int          N       = 128;
    localparam int          LIMIT   = 5000;
    localparam logic [63:0] SEED    = 64'h0123_4567_89AB_0000;
    localparam logic [71:0] EXP_CMD = 72'h05_0000_1000_4080_0400;

    logic        clk = 0, rst_n = 0;
    logic        i_s2mm_wr_cmd_tready = 0, i_s2mm_wr_tready = 0, i_s2mm_sts_tvalid = 0;
    logic        i_s2mm_sts_tkeep = 0, i_s2mm_sts_tlast = 0, i_mm2s_rd_cmd_tready = 0;
    logic [7:0]  i_s2mm_sts_tdata = 0, i_mm2s_rd_tkeep = 0;
    logic [63:0] i_mm2s_rd_tdata = 0;
    logic        i_mm2s_rd_tvalid = 0, i_mm2s_rd_tlast = 0;
    logic [71:0] o_s2mm_wr_cmd_tdata, o_mm2s_rd_cmd_tdata;
    logic [63:0] o_s2mm_wr_tdata;
    logic [7:0]  o_s2mm_wr_tkeep;
    logic        o_s2mm_wr_cmd_tvalid, o_s2mm_wr_tvalid, o_s2mm_wr_tlast, o_mm2s_rd_cmd_tvalid;
    logic        o_mm2s_rd_tready, o_done, o_pass;
    logic [15:0] o_err_cnt;

    int checks = 0, errors = 0;
    int wr_n, wr_last_cnt, wr_last_idx, wr_keep_bad, rd_acc, model_err;
    logic tmo, rd_seen, wr_after;
    logic [71:0] wr_cmd, rd_cmd;
    logic [63:0] wr_data [0:N-1];

    datamover_validator dut (
        .clk(clk), .rst_n(rst_n),
        .i_s2mm_wr_cmd_tready(i_s2mm_wr_cmd_tready), .o_s2mm_wr_cmd_tdata(o_s2mm_wr_cmd_tdata),
        .o_s2mm_wr_cmd_tvalid(o_s2mm_wr_cmd_tvalid), .o_s2mm_wr_tdata(o_s2mm_wr_tdata),
        .o_s2mm_wr_tkeep(o_s2mm_wr_tkeep), .o_s2mm_wr_tvalid(o_s2mm_wr_tvalid),
        .o_s2mm_wr_tlast(o_s2mm_wr_tlast), .i_s2mm_wr_tready(i_s2mm_wr_tready),
        .i_s2mm_sts_tdata(i_s2mm_sts_tdata), .i_s2mm_sts_tvalid(i_s2mm_sts_tvalid),
        .i_s2mm_sts_tkeep(i_s2mm_sts_tkeep), .i_s2mm_sts_tlast(i_s2mm_sts_tlast),
        .i_mm2s_rd_cmd_tready(i_mm2s_rd_cmd_tready), .o_mm2s_rd_cmd_tdata(o_mm2s_rd_cmd_tdata),
        .o_mm2s_rd_cmd_tvalid(o_mm2s_rd_cmd_tvalid), .i_mm2s_rd_tdata(i_mm2s_rd_tdata),
        .i_mm2s_rd_tkeep(i_mm2s_rd_tkeep), .i_mm2s_rd_tvalid(i_mm2s_rd_tvalid),
        .i_mm2s_rd_tlast(i_mm2s_rd_tlast), .o_mm2s_rd_tready(o_mm2s_rd_tready),
        .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 0;
        {i_s2mm_wr_cmd_tready, i_s2mm_wr_tready, i_s2mm_sts_tvalid, i_mm2s_rd_cmd_tready} = '0;
        {i_mm2s_rd_tvalid, i_mm2s_rd_tlast, i_s2mm_sts_tdata, i_mm2s_rd_tkeep, i_mm2s_rd_tdata} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    // DataMover + RAM model: records what the DUT writes, returns it (optionally faulted) and scores the expected error count
    task automatic dm_run(input logic [7:0] sts, input int bad_beat, input logic [63:0] bad_xor,
                          input int keep_beat, input logic [7:0] keep_val, input int last_beat);
        int cyc, j, stop;
        logic lst, mm;
        logic [63:0] d, e;
        logic [7:0] k;
        tmo = 0; rd_seen = 0; wr_after = 0; wr_n = 0; wr_last_cnt = 0; wr_last_idx = -1;
        wr_keep_bad = 0; rd_acc = 0; model_err = 0; wr_cmd = '0; rd_cmd = '0; cyc = 0;
        do begin
            @(negedge clk);
            i_s2mm_wr_cmd_tready = 1'($urandom_range(0, 1));
            cyc++;
        end while (!(o_s2mm_wr_cmd_tvalid && i_s2mm_wr_cmd_tready) && cyc < LIMIT);
        if (!(o_s2mm_wr_cmd_tvalid && i_s2mm_wr_cmd_tready)) begin tmo = 1; return; end
        wr_cmd = o_s2mm_wr_cmd_tdata;
        cyc = 0;
        while (wr_n < N && cyc < LIMIT) begin
            @(negedge clk);
            i_s2mm_wr_cmd_tready = 0;
            i_s2mm_wr_tready = 1'($urandom_range(0, 1));
            i_s2mm_sts_tdata = 8'h00;
            i_s2mm_sts_tvalid = $urandom_range(0, 7) == 0;
            if (o_s2mm_wr_tvalid && i_s2mm_wr_tready) begin
                wr_data[wr_n] = o_s2mm_wr_tdata;
                if (o_s2mm_wr_tkeep != 8'hFF) wr_keep_bad++;
                if (o_s2mm_wr_tlast) begin wr_last_cnt++; wr_last_idx = wr_n; end
                wr_n++;
            end
            cyc++;
        end
        if (wr_n < N) begin tmo = 1; return; end
        @(negedge clk);
        i_s2mm_wr_tready = 0; i_s2mm_sts_tvalid = 0;
        wr_after = o_s2mm_wr_tvalid;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        i_s2mm_sts_tdata = sts; i_s2mm_sts_tvalid = 1;
        @(negedge clk);
        i_s2mm_sts_tvalid = 0;
        if (!(sts[7] && sts[6:4] == 3'd0 && sts[3:0] == 4'h5)) model_err = 1;
        for (cyc = 0; cyc < 200 && !rd_seen; cyc++) begin
            @(negedge clk);
            i_mm2s_rd_cmd_tready = 1'($urandom_range(0, 1));
            if (o_mm2s_rd_cmd_tvalid && i_mm2s_rd_cmd_tready) begin rd_seen = 1; rd_cmd = o_mm2s_rd_cmd_tdata; end
        end
        if (rd_seen) begin
            stop = last_beat >= 0 ? last_beat : N - 1;
            j = 0; cyc = 0;
            while (j <= stop && cyc < LIMIT) begin
                d = wr_data[j] ^ (j == bad_beat ? bad_xor : 64'd0);
                k = j == keep_beat ? keep_val : 8'hFF;
                lst = j == last_beat;
                @(negedge clk);
                i_mm2s_rd_cmd_tready = 0;
                i_mm2s_rd_tvalid = 1'($urandom_range(0, 1));
                i_mm2s_rd_tdata = d; i_mm2s_rd_tkeep = k; i_mm2s_rd_tlast = lst;
                if (i_mm2s_rd_tvalid && o_mm2s_rd_tready) begin
                    e = SEED + 64'(j);
                    mm = 0;
                    for (int b = 0; b < 8; b++) if (k[b] && d[8*b +: 8] != e[8*b +: 8]) mm = 1;
                    model_err += int'(mm) + int'(k != 8'hFF) + int'(lst && j != N - 1) + int'(!lst && j == N - 1);
                    j++;
                end
                cyc++;
            end
            rd_acc = j;
        end
        @(negedge clk);
        i_mm2s_rd_tvalid = 0; i_mm2s_rd_tlast = 0; i_mm2s_rd_cmd_tready = 0;
        for (cyc = 0; cyc < LIMIT && !o_done; cyc++) @(negedge clk);
        if (!o_done) tmo = 1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        #1;
        checks++;
        if ({o_s2mm_wr_cmd_tvalid, o_s2mm_wr_tvalid, o_s2mm_wr_tlast, o_mm2s_rd_cmd_tvalid, o_mm2s_rd_tready, o_done, o_pass} !== 7'd0) begin
            errors++; $display("FAIL reset_flags got %b want 0", {o_s2mm_wr_cmd_tvalid, o_s2mm_wr_tvalid, o_s2mm_wr_tlast, o_mm2s_rd_cmd_tvalid, o_mm2s_rd_tready, o_done, o_pass});
        end
        checks++;
        if ({o_s2mm_wr_cmd_tdata, o_mm2s_rd_cmd_tdata, o_s2mm_wr_tdata, o_err_cnt} !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", {o_s2mm_wr_cmd_tdata, o_mm2s_rd_cmd_tdata, o_s2mm_wr_tdata, o_err_cnt});
        end
        do_reset;
        #1;
        checks++;
        if (o_s2mm_wr_cmd_tvalid !== 1'b0) begin errors++; $display("FAIL idle_cycle got %b want 0", o_s2mm_wr_cmd_tvalid); end
        @(negedge clk);
        checks++;
        if (o_s2mm_wr_cmd_tvalid !== 1'b1 || o_s2mm_wr_cmd_tdata !== EXP_CMD) begin
            errors++; $display("FAIL first_cmd got %b %h want 1 %h", o_s2mm_wr_cmd_tvalid, o_s2mm_wr_cmd_tdata, EXP_CMD);
        end
    endtask

    task automatic test_clean;
        do_reset;
        dm_run(8'h85, -1, 64'd0, -1, 8'hFF, N - 1);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL clean_timeout got %b want 0", tmo); end
        checks++; if (wr_cmd !== EXP_CMD) begin errors++; $display("FAIL wr_cmd got %h want %h", wr_cmd, EXP_CMD); end
        checks++; if (rd_cmd !== EXP_CMD) begin errors++; $display("FAIL rd_cmd got %h want %h", rd_cmd, EXP_CMD); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (wr_data[i] !== SEED + 64'(i)) begin errors++; $display("FAIL wr_beat%0d got %h want %h", i, wr_data[i], SEED + 64'(i)); end
        end
        checks++; if (wr_last_cnt !== 1 || wr_last_idx !== N - 1) begin errors++; $display("FAIL wr_tlast got %0d@%0d want 1@%0d", wr_last_cnt, wr_last_idx, N - 1); end
        checks++; if (wr_keep_bad !== 0) begin errors++; $display("FAIL wr_keep got %0d bad want 0", wr_keep_bad); end
        checks++; if (wr_after !== 1'b0) begin errors++; $display("FAIL wr_valid_after got %b want 0", wr_after); end
        checks++; if (rd_acc !== N) begin errors++; $display("FAIL clean_rd_beats got %0d want %0d", rd_acc, N); end
        checks++; if ({o_done, o_pass, o_err_cnt} !== {2'b11, 16'(model_err)}) begin
            errors++; $display("FAIL clean_result got %b%b %0d want 11 %0d", o_done, o_pass, o_err_cnt, model_err);
        end
        repeat (20) @(negedge clk);
        checks++; if ({o_done, o_mm2s_rd_tready, o_s2mm_wr_cmd_tvalid} !== 3'b100) begin
            errors++; $display("FAIL done_sticky got %b want 100", {o_done, o_mm2s_rd_tready, o_s2mm_wr_cmd_tvalid});
        end
    endtask

    task automatic test_bad_status;
        do_reset;
        dm_run(8'h45, -1, 64'd0, -1, 8'hFF, N - 1);
        checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL bad_sts_rd_cmd got %b want 0", rd_seen); end
        checks++; if ({o_done, o_pass, o_err_cnt} !== {2'b10, 16'(model_err)}) begin
            errors++; $display("FAIL bad_sts_result got %b%b %0d want 10 %0d", o_done, o_pass, o_err_cnt, model_err);
        end
    endtask

    task automatic test_faults;
        int kb;
        do_reset;
        dm_run(8'h85, 10, 64'h1, -1, 8'hFF, N - 1);
        checks++; if (rd_acc !== N) begin errors++; $display("FAIL corrupt_drain got %0d want %0d", rd_acc, N); end
        checks++; if ({o_done, o_pass, o_err_cnt} !== {2'b10, 16'(model_err)}) begin
            errors++; $display("FAIL corrupt_result got %b%b %0d want 10 %0d", o_done, o_pass, o_err_cnt, model_err);
        end
        kb = $urandom_range(0, N - 2);
        do_reset;
        dm_run(8'h85, kb, 64'hFF, kb, 8'hF0, N - 1);
        checks++; if (o_err_cnt !== 16'(model_err)) begin errors++; $display("FAIL keep_masked got %0d want %0d", o_err_cnt, model_err); end
        do_reset;
        dm_run(8'h85, -1, 64'd0, -1, 8'hFF, 63);
        checks++; if (rd_acc !== 64 || o_err_cnt !== 16'(model_err)) begin
            errors++; $display("FAIL early_tlast got %0d beats %0d err want 64 beats %0d err", rd_acc, o_err_cnt, model_err);
        end
        do_reset;
        dm_run(8'h85, -1, 64'd0, -1, 8'hFF, -1);
        checks++; if ({o_done, o_pass, o_err_cnt} !== {2'b10, 16'(model_err)} || rd_acc !== N) begin
            errors++; $display("FAIL missing_tlast got %b%b %0d/%0d want 10 %0d/%0d", o_done, o_pass, o_err_cnt, rd_acc, model_err, N);
        end
    endtask

    task automatic test_random;
        logic [7:0] sts;
        for (int r = 0; r < 4; r++) begin
            sts = $urandom_range(0, 1) ? 8'h85 : 8'($urandom);
            do_reset;
            dm_run(sts, $urandom_range(0, N - 1), {$urandom, $urandom}, $urandom_range(0, 3) == 0 ? $urandom_range(0, N - 1) : -1,
                   8'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(0, N - 1) : N - 1);
            checks++; if (tmo !== 1'b0 || o_err_cnt !== 16'(model_err) || o_pass !== (model_err == 0)) begin
                errors++; $display("FAIL random%0d sts %h got err %0d pass %b tmo %b want err %0d", r, sts, o_err_cnt, o_pass, tmo, model_err);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, cyc;
        do_reset;
        i_s2mm_wr_cmd_tready = 1; i_s2mm_wr_tready = 1;
        n = 0; cyc = 0;
        while (n < 50 && cyc < 500) begin
            @(negedge clk);
            if (o_s2mm_wr_tvalid) n++;
            cyc++;
        end
        @(negedge clk);
        checks++; if (o_s2mm_wr_tvalid !== 1'b1 || o_s2mm_wr_tdata !== SEED + 64'd50) begin
            errors++; $display("FAIL beat50 got %b %h want 1 %h", o_s2mm_wr_tvalid, o_s2mm_wr_tdata, SEED + 64'd50);
        end
        #2 rst_n = 0;
        #1;
        checks++; if ({o_s2mm_wr_tvalid, o_s2mm_wr_tdata, o_s2mm_wr_tlast, o_s2mm_wr_cmd_tvalid, o_done, o_err_cnt} !== '0) begin
            errors++; $display("FAIL async_reset got %b %h want all 0", o_s2mm_wr_tvalid, o_s2mm_wr_tdata);
        end
        do_reset;
        dm_run(8'h85, -1, 64'd0, -1, 8'hFF, N - 1);
        checks++; if (tmo !== 1'b0 || {o_done, o_pass, o_err_cnt} !== 18'h30000 || wr_data[0] !== SEED) begin
            errors++; $display("FAIL rerun got %b%b %0d first %h tmo %b want 11 0 %h", o_done, o_pass, o_err_cnt, wr_data[0], tmo, SEED);
        end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_bad_status;
        test_faults;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
